shared_reg_arbiter: RTL and testbench
=====================================

// Module: shared_reg_arbiter
// PURPOSE
//  Round-robin arbiter sharing one W-bit D-flip-flop register bank among N requesters.
//  It grants exclusive write access, latches the owner's data into the bank and reports
//  which requester wrote last. It sits between requester FSMs and the shared register.
//  A hold limit stops one requester from starving the others.
// PARAMETERS
//  N         4   number of requesters (>=2)
//  W         8   width of shared register / each data word
//  MAX_HOLD  4   max consecutive write cycles per grant while others wait (>=1)
// PORTS
//  clk       in   1         rising-edge clock, sole clock domain
//  reset     in   1         synchronous, active-low: reset==0 at posedge resets block
//  req       in   N         req[i]=1: requester i wants / keeps the register
//  data_in   in   N*W       requester i word at data_in[i*W +: W]
//  gnt       out  N         one-hot grant, registered; all-zero when idle
//  q         out  W         shared register contents
//  q_valid   out  1         1 for the cycle after each edge that wrote q
//  owner     out  clog2(N)  index of current/last grantee
//  busy      out  1         1 while in BUSY state (gnt != 0)
// BEHAVIOUR
//  Reset (reset==0 at posedge): gnt=0, q=0, q_valid=0, owner=0, busy=0, ptr=0,
//   hold_cnt=0, state=IDLE. Reset overrides all other activity, including mid-grant.
//  State IDLE: at an edge with req!=0, grant the first set req bit at or after ptr,
//   searching cyclically. gnt becomes one-hot, owner=index, hold_cnt=0, go to BUSY.
//   req-to-gnt latency is 1 cycle. No write occurs on the granting edge.
//  State BUSY, owner k:
//   - req[k]=1 at edge: q<=data_in[k], q_valid<=1, hold_cnt++ (saturates at MAX_HOLD).
//   - Release when req[k]=0 at edge: no write; q_valid<=0; ptr<=k+1 mod N.
//   - Forced release: on the write edge where hold_cnt reaches MAX_HOLD while any
//     other req bit is 1. The write still happens; ptr<=k+1 mod N.
//   - If no other requester waits, the owner keeps gnt indefinitely.
//   - Handover: on any release edge, if other req bits are set, grant the next one
//     cyclically from k+1 on that same edge (no idle bubble), hold_cnt=0. Otherwise
//     gnt=0 and state=IDLE.
//  q_valid=0 on every edge without a write. q holds its value when not written.
//  owner keeps the last grantee's index in IDLE.
//  A req from a non-owner while BUSY has no effect until release.
//  Width rules: hold_cnt is clog2(MAX_HOLD+1) bits. ptr and owner are clog2(N) bits
//   and wrap N-1 -> 0.
// STRUCTURE
//  Package arb_pkg: state encoding localparams ST_IDLE=1'b0, ST_BUSY=1'b1, and a
//   clog2 helper function.
//  Sub-module rr_pick (combinational): inputs req[N-1:0] and ptr; outputs found and
//   idx. Finds the first set bit at or after ptr, cyclically. Instantiated once and
//   fed req with the owner bit masked during BUSY.
//  The top level holds the FSM, hold counter, pointer and the W-bit q register.
// TESTING (N=4, W=8, MAX_HOLD=4)
//  1 Hold reset=0 for 2 edges with req=1111 -> gnt=0000, q=00, q_valid=0, owner=0, busy=0.
//  2 req=0100, data2=A5 held 3 cycles, then dropped -> gnt=0100 after 1 edge;
//    q=A5 and q_valid=1 for 3 cycles; gnt=0000 and busy=0 the edge after the drop.
//  3 From reset, req=1011 with each requester dropping after 1 write ->
//    gnt sequence 0001, 0010, 1000 with no 0000 between grants.
//  4 req[0] held with data0=11, req[3] raised after the 2nd write -> gnt moves to 1000
//    after the 4th write of 11. If req[0] is alone, gnt=0001 holds for 20+ cycles.
//  5 reset=0 for 1 edge while gnt=0100 mid-write -> gnt=0000, q=00, ptr=0;
//    with req[2] still high, gnt=0100 one edge after reset=1.
//  6 Wrap: owner=3 releases with req=1001 pending -> next gnt=0001 (ptr wrapped to 0).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin register arbiter: FSM states and a
// width helper usable in parameter expressions.
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic first-set-bit search: returns the first requester at or after ptr.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            logic [IW-1:0] j;
            j = IW'((32'(ptr) + i) % N);
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting exclusive write access to one shared W-bit
// register, with a hold limit so a busy owner cannot starve waiting requesters.
module shared_reg_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned N        = 4,
    parameter  int unsigned W        = 8,
    parameter  int unsigned MAX_HOLD = 4,
    localparam int unsigned IW       = clog2(N),
    localparam int unsigned HW       = clog2(MAX_HOLD + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   q,
    output logic           q_valid,
    output logic [IW-1:0]  owner,
    output logic           busy
);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [HW-1:0] hold_cnt;

    logic [W-1:0]  words [N];
    logic [N-1:0]  pick_req;
    logic [IW-1:0] pick_ptr;
    logic [IW-1:0] owner_next_idx;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic [HW-1:0] hold_inc;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            words[i] = data_in[i*W +: W];
        end
    end

    assign owner_next_idx = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
    assign hold_inc       = (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;

    // While busy the owner is excluded and the search starts just past it,
    // so the same pick serves both the idle grant and a same-edge handover.
    assign pick_req = (state == ST_BUSY) ? (req & ~gnt) : req;
    assign pick_ptr = (state == ST_BUSY) ? owner_next_idx : ptr;

    rr_pick #(.N(N)) u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign busy = (state == ST_BUSY);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            q        <= '0;
            q_valid  <= 1'b0;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    q_valid <= 1'b0;
                    if (pick_found) begin
                        state    <= ST_BUSY;
                        gnt      <= N'(1) << pick_idx;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                    end
                end
                ST_BUSY: begin
                    if (req[owner]) begin
                        q       <= words[owner];
                        q_valid <= 1'b1;
                        if (hold_inc == HW'(MAX_HOLD) && pick_found) begin
                            ptr      <= owner_next_idx;
                            gnt      <= N'(1) << pick_idx;
                            owner    <= pick_idx;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_inc;
                        end
                    end else begin
                        q_valid  <= 1'b0;
                        ptr      <= owner_next_idx;
                        hold_cnt <= '0;
                        if (pick_found) begin
                            gnt   <= N'(1) << pick_idx;
                            owner <= pick_idx;
                        end else begin
                            gnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (N=4, W=8, MAX_HOLD=4).
module tb_shared_reg_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic           q_valid;
    logic [1:0]     owner;
    logic           busy;

    int unsigned n_checks;
    int unsigned n_errors;

    shared_reg_arbiter #(.N(4), .W(8), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .data_in (data_in),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .owner   (owner),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int unsigned i, input logic [W-1:0] v);
        data_in[i*W +: W] = v;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        req      = '0;
        data_in  = '0;

        // 1: reset dominates active requests
        req = 4'b1111;
        tick(); tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_q", 32'(q), 32'h0);
        check("rst_qv", 32'(q_valid), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // 2: single requester, three writes, then release
        reset = 1'b1;
        req   = 4'b0100;
        set_word(2, 8'hA5);
        tick();
        check("t2_gnt", 32'(gnt), 32'h4);
        check("t2_owner", 32'(owner), 32'h2);
        check("t2_busy", 32'(busy), 32'h1);
        check("t2_nowrite_qv", 32'(q_valid), 32'h0);
        check("t2_nowrite_q", 32'(q), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2_q", 32'(q), 32'hA5);
            check("t2_qv", 32'(q_valid), 32'h1);
            check("t2_gnt_hold", 32'(gnt), 32'h4);
        end
        req = 4'b0000;
        tick();
        check("t2_rel_gnt", 32'(gnt), 32'h0);
        check("t2_rel_busy", 32'(busy), 32'h0);
        check("t2_rel_qv", 32'(q_valid), 32'h0);
        check("t2_rel_q", 32'(q), 32'hA5);
        check("t2_rel_owner", 32'(owner), 32'h2);

        // 3: handover chain 0 -> 1 -> 3 without idle gaps
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_word(0, 8'h01);
        set_word(1, 8'h02);
        set_word(3, 8'h04);
        req = 4'b1011;
        tick();
        check("t3_g0", 32'(gnt), 32'h1);
        tick();
        check("t3_q0", 32'(q), 32'h01);
        req = 4'b1010;
        tick();
        check("t3_g1", 32'(gnt), 32'h2);
        check("t3_g1_qv", 32'(q_valid), 32'h0);
        tick();
        check("t3_q1", 32'(q), 32'h02);
        req = 4'b1000;
        tick();
        check("t3_g3", 32'(gnt), 32'h8);
        check("t3_g3_owner", 32'(owner), 32'h3);
        tick();
        check("t3_q3", 32'(q), 32'h04);
        req = 4'b0000;
        tick();
        check("t3_idle", 32'(gnt), 32'h0);

        // 4: hold limit forces release after the 4th write
        set_word(0, 8'h11);
        set_word(3, 8'h33);
        req = 4'b0001;
        tick();
        check("t4_g0", 32'(gnt), 32'h1);
        tick(); tick();
        req = 4'b1001;
        tick();
        check("t4_w3_gnt", 32'(gnt), 32'h1);
        check("t4_w3_q", 32'(q), 32'h11);
        tick();
        check("t4_w4_q", 32'(q), 32'h11);
        check("t4_w4_qv", 32'(q_valid), 32'h1);
        check("t4_force_gnt", 32'(gnt), 32'h8);
        check("t4_force_owner", 32'(owner), 32'h3);

        // 6: owner 3 forced out with req[0] pending wraps to requester 0
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_hold_gnt", 32'(gnt), 32'h8);
            check("t6_q", 32'(q), 32'h33);
        end
        tick();
        check("t6_wrap_gnt", 32'(gnt), 32'h1);
        check("t6_wrap_owner", 32'(owner), 32'h0);
        check("t6_wrap_q", 32'(q), 32'h33);

        // 4b: a lone requester is never forced out
        req = 4'b0001;
        for (int k = 0; k < 22; k++) begin
            tick();
            check("t4_alone_gnt", 32'(gnt), 32'h1);
            check("t4_alone_q", 32'(q), 32'h11);
        end

        // 5: reset mid-write clears everything, then regrant
        req = 4'b0000;
        tick();
        set_word(2, 8'h5A);
        req = 4'b0100;
        tick();
        check("t5_g2", 32'(gnt), 32'h4);
        tick();
        check("t5_q", 32'(q), 32'h5A);
        reset = 1'b0;
        tick();
        check("t5_rst_gnt", 32'(gnt), 32'h0);
        check("t5_rst_q", 32'(q), 32'h0);
        check("t5_rst_qv", 32'(q_valid), 32'h0);
        check("t5_rst_owner", 32'(owner), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        tick();
        check("t5_regrant", 32'(gnt), 32'h4);
        check("t5_regrant_qv", 32'(q_valid), 32'h0);
        req = 4'b0110;
        tick();
        req = 4'b0010;
        tick();
        check("t5_after_ptr", 32'(gnt), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
